mem_port_arbiter: RTL and testbench

//  Shares one single-port instruction/data memory between the IF stage (fetch) and the
//  MEM stage (M_mem_read / M_mem_write) of the 5-stage RV32 pipeline.

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch stage and the data stage.
// Data has strict priority. Each access returns registered data and a one-cycle done pulse.
module mem_port_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_done,
    input  logic            d_rd,
    input  logic            d_wr,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic [DW-1:0]   d_rdata,
    output logic            d_done,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_ready,
    input  logic [DW-1:0]   mem_rdata,
    output logic            stall_if,
    output logic            stall_mem,
    output logic            bus_err,
    output logic [2:0]      o_dbg_state
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] GRANT_I = 3'd1;
    localparam logic [2:0] GRANT_D = 3'd2;
    localparam logic [2:0] RESP_I  = 3'd3;
    localparam logic [2:0] RESP_D  = 3'd4;

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [2:0]      r_state;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic [DW/8-1:0] r_mem_be;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_d_rdata;
    logic            r_if_done;
    logic            r_d_done;
    logic            r_bus_err;
    logic [CW-1:0]   r_cnt;

    logic            w_d_any;
    logic            w_timeout;

    assign w_d_any   = d_rd | d_wr;
    // Fires on the last permitted wait cycle, so the done pulse follows TIMEOUT_CYCLES waits.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

    // Handshake: a transfer completes on any rising edge where mem_req && mem_ready;
    // mem_req and all mem_* fields stay stable from grant until that edge (or timeout),
    // and mem_ready seen while mem_req is low has no effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_done   <= 1'b0;
            r_d_done    <= 1'b0;
            r_bus_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_d_any) begin
                        r_state     <= GRANT_D;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= d_wr;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_mem_be    <= d_wr ? d_be : '1;
                        r_cnt       <= '0;
                    end else if (if_req) begin
                        r_state     <= GRANT_I;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= '0;
                        r_mem_be    <= '1;
                        r_cnt       <= '0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (mem_ready || w_timeout) begin
                        r_mem_req <= 1'b0;
                        if (!mem_ready) r_bus_err <= 1'b1;
                        if (r_state == GRANT_I) begin
                            r_if_rdata <= mem_ready ? mem_rdata : '0;
                            r_if_done  <= 1'b1;
                            r_state    <= RESP_I;
                        end else begin
                            r_d_rdata <= (mem_ready && !r_mem_we) ? mem_rdata : '0;
                            r_d_done  <= 1'b1;
                            r_state   <= RESP_D;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP_I: begin
                    r_if_done <= 1'b0;
                    r_state   <= IDLE;
                end
                RESP_D: begin
                    r_d_done <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_be      = r_mem_be;
    assign if_rdata    = r_if_rdata;
    assign d_rdata     = r_d_rdata;
    assign if_done     = r_if_done;
    assign d_done      = r_d_done;
    assign bus_err     = r_bus_err;
    assign stall_if    = if_req & ~r_if_done;
    assign stall_mem   = w_d_any & ~r_d_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-exact checks of grant order, latency,
// stalls, write handling, timeout and asynchronous reset.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GRANT_I = 3'd1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic [DW-1:0]   if_rdata;
    logic            if_done;
    logic            d_rd;
    logic            d_wr;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_be;
    logic [DW-1:0]   d_rdata;
    logic            d_done;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic            mem_ready;
    logic [DW-1:0]   mem_rdata;
    logic            stall_if;
    logic            stall_mem;
    logic            bus_err;
    logic [2:0]      dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err),
        .o_dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_done_data(input string tag, input logic [DW-1:0] got);
        if (exp_q.size() == 0) begin
            chk({tag, "_q_empty"}, 32'd1, 32'd0);
        end else begin
            chk(tag, got, exp_q.pop_front());
        end
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        d_rd      = 1'b0;
        d_wr      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_be      = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_done", {30'd0, if_done, d_done}, 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: fetch only, memory always ready
        if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
        exp_q.push_back(32'h0050_0093);
        #1;
        chk("t1_c0_stall_if", 32'(stall_if), 32'd1);
        chk("t1_c0_mem_req", 32'(mem_req), 32'd0);
        tick();
        chk("t1_c1_mem_req", 32'(mem_req), 32'd1);
        chk("t1_c1_mem_addr", mem_addr, 32'h100);
        chk("t1_c1_mem_we", 32'(mem_we), 32'd0);
        chk("t1_c1_mem_be", 32'(mem_be), 32'hF);
        chk("t1_c1_state", 32'(dbg_state), 32'(S_GRANT_I));
        tick();
        chk("t1_c2_if_done", 32'(if_done), 32'd1);
        check_done_data("t1_c2_if_rdata", if_rdata);
        chk("t1_c2_stall_if", 32'(stall_if), 32'd0);
        chk("t1_c2_mem_req", 32'(mem_req), 32'd0);
        if_req = 1'b0;
        tick();
        chk("t1_c3_if_done", 32'(if_done), 32'd0);
        chk("t1_c3_state", 32'(dbg_state), 32'(S_IDLE));

        // 2: simultaneous fetch and load, data wins
        if_req = 1'b1; if_addr = 32'h104; d_rd = 1'b1; d_addr = 32'h2000;
        mem_rdata = 32'h1122_3344;
        exp_q.push_back(32'h1122_3344);
        exp_q.push_back(32'h00A0_0113);
        #1;
        chk("t2_c0_stalls", {30'd0, stall_if, stall_mem}, 32'd3);
        tick();
        chk("t2_c1_mem_addr", mem_addr, 32'h2000);
        chk("t2_c1_mem_req", 32'(mem_req), 32'd1);
        chk("t2_c1_stall_if", 32'(stall_if), 32'd1);
        tick();
        chk("t2_c2_d_done", 32'(d_done), 32'd1);
        check_done_data("t2_c2_d_rdata", d_rdata);
        chk("t2_c2_stalls", {30'd0, stall_if, stall_mem}, 32'd2);
        chk("t2_c2_if_done", 32'(if_done), 32'd0);
        d_rd = 1'b0; mem_rdata = 32'h00A0_0113;
        tick();
        chk("t2_c3_mem_req", 32'(mem_req), 32'd0);
        chk("t2_c3_stall_if", 32'(stall_if), 32'd1);
        tick();
        chk("t2_c4_mem_req", 32'(mem_req), 32'd1);
        chk("t2_c4_mem_addr", mem_addr, 32'h104);
        chk("t2_c4_stall_if", 32'(stall_if), 32'd1);
        tick();
        chk("t2_c5_if_done", 32'(if_done), 32'd1);
        check_done_data("t2_c5_if_rdata", if_rdata);
        chk("t2_c5_stall_if", 32'(stall_if), 32'd0);
        if_req = 1'b0;
        tick();

        // 3: store with ready delayed three cycles
        d_wr = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
        mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        tick();
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("t3_c%0d_mem_req", k), 32'(mem_req), 32'd1);
            chk($sformatf("t3_c%0d_mem_we", k), 32'(mem_we), 32'd1);
            chk($sformatf("t3_c%0d_mem_addr", k), mem_addr, 32'h2004);
            chk($sformatf("t3_c%0d_mem_wdata", k), mem_wdata, 32'hDEAD_BEEF);
            chk($sformatf("t3_c%0d_mem_be", k), 32'(mem_be), 32'h3);
            chk($sformatf("t3_c%0d_d_done", k), 32'(d_done), 32'd0);
            if (k == 4) mem_ready = 1'b1;
            tick();
        end
        chk("t3_c5_d_done", 32'(d_done), 32'd1);
        chk("t3_c5_d_rdata", d_rdata, 32'd0);
        chk("t3_c5_bus_err", 32'(bus_err), 32'd0);
        d_wr = 1'b0;
        tick();

        // both d_rd and d_wr: treated as write, read data forced to zero
        d_rd = 1'b1; d_wr = 1'b1; d_addr = 32'h2008; d_wdata = 32'h0000_55AA; d_be = 4'b1111;
        mem_rdata = 32'h1234_5678;
        tick();
        chk("t3b_c1_mem_we", 32'(mem_we), 32'd1);
        chk("t3b_c1_mem_wdata", mem_wdata, 32'h0000_55AA);
        tick();
        chk("t3b_c2_d_done", 32'(d_done), 32'd1);
        chk("t3b_c2_d_rdata", d_rdata, 32'd0);
        d_rd = 1'b0; d_wr = 1'b0;
        tick();
        tick();
        chk("idle_ready_ignored", {28'd0, dbg_state, mem_req}, 32'd0);

        // 4: timeout with memory never ready
        d_rd = 1'b1; d_addr = 32'h3000; mem_ready = 1'b0; mem_rdata = 32'hCAFE_F00D;
        tick();
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("t4_c%0d_mem_req", k), 32'(mem_req), 32'd1);
            chk($sformatf("t4_c%0d_bus_err", k), 32'(bus_err), 32'd0);
            chk($sformatf("t4_c%0d_d_done", k), 32'(d_done), 32'd0);
            tick();
        end
        chk("t4_c5_d_done", 32'(d_done), 32'd1);
        chk("t4_c5_d_rdata", d_rdata, 32'd0);
        chk("t4_c5_bus_err", 32'(bus_err), 32'd1);
        chk("t4_c5_mem_req", 32'(mem_req), 32'd0);
        d_rd = 1'b0;
        tick();
        if_req = 1'b1; if_addr = 32'h108; mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
        exp_q.push_back(32'h0000_0013);
        tick();
        chk("t4_f_mem_addr", mem_addr, 32'h108);
        tick();
        chk("t4_f_if_done", 32'(if_done), 32'd1);
        check_done_data("t4_f_if_rdata", if_rdata);
        chk("t4_f_bus_err", 32'(bus_err), 32'd1);
        if_req = 1'b0;
        tick();

        // 5: reset in the middle of a fetch grant
        if_req = 1'b1; if_addr = 32'h10C; mem_ready = 1'b0;
        tick();
        chk("t5_pre_mem_req", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_mem_req", 32'(mem_req), 32'd0);
        chk("t5_rst_if_done", 32'(if_done), 32'd0);
        chk("t5_rst_bus_err", 32'(bus_err), 32'd0);
        chk("t5_rst_state", 32'(dbg_state), 32'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1; mem_rdata = 32'h0000_0073;
        exp_q.push_back(32'h0000_0073);
        tick();
        chk("t5_c1_mem_req", 32'(mem_req), 32'd1);
        chk("t5_c1_mem_addr", mem_addr, 32'h10C);
        tick();
        chk("t5_c2_if_done", 32'(if_done), 32'd1);
        check_done_data("t5_c2_if_rdata", if_rdata);
        if_req = 1'b0;
        tick();
        chk("final_exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
